// File: rtl/fighter_ai_ctrl.sv
// AI opponent brain: drives move/jump strobes for a player_move from position feedback.
// Optional FIGHTER_AI_REACTIVE_EN adds opponent_jump_active and a retreat-on-enemy-jump reflex.
module fighter_ai_ctrl #(
  parameter int          POS_WIDTH   = 10,
  parameter int          NEAR_DIST   = 40,
  parameter int          FAR_DIST    = 120,
  parameter int          THINK_TICKS = 8,
  parameter int          JUMP_HOLD   = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCEN,
  input  logic                 ai_enable,
  input  logic [POS_WIDTH-1:0] self_x,
  input  logic [POS_WIDTH-1:0] opponent_x,
  input  logic                 self_jump_active,
  input  logic                 self_x_lock,
`ifdef FIGHTER_AI_REACTIVE_EN
  input  logic                 opponent_jump_active,
`endif
  output logic                 move_left,
  output logic                 move_right,
  output logic                 jump,
  output logic [2:0]           ai_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_THINK    = 3'd1;
  localparam logic [2:0] S_APPROACH = 3'd2;
  localparam logic [2:0] S_RETREAT  = 3'd3;
  localparam logic [2:0] S_JUMP     = 3'd4;
  localparam logic [2:0] S_COOLDOWN = 3'd5;

  localparam int CNT_MAX = (THINK_TICKS > JUMP_HOLD) ? THINK_TICKS : JUMP_HOLD;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] THINK_LOAD = CNT_W'(THINK_TICKS - 1);
  localparam logic [CNT_W-1:0] JUMP_LOAD  = CNT_W'(JUMP_HOLD - 1);
  localparam logic [POS_WIDTH-1:0] NEAR_V = POS_WIDTH'(NEAR_DIST);
  localparam logic [POS_WIDTH-1:0] FAR_V  = POS_WIDTH'(FAR_DIST);
  // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [15:0]          r_lfsr;
  logic                 r_move_left, r_move_right, r_jump;

  logic                 w_toward_right;
  logic [POS_WIDTH-1:0] w_dist;
  logic                 w_cnt_zero;
  logic [CNT_W-1:0]     w_cnt_dec;
  logic [1:0]           w_r;
  logic [15:0]          w_lfsr_next;
  logic [2:0]           w_state_next;
  logic [CNT_W-1:0]     w_cnt_next;

  always_comb begin
    w_toward_right = (opponent_x >= self_x);
    w_dist         = w_toward_right ? (opponent_x - self_x) : (self_x - opponent_x);
    w_cnt_zero     = (r_cnt == '0);
    w_cnt_dec      = r_cnt - CNT_W'(1);
    w_r            = r_lfsr[1:0];
    w_lfsr_next    = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    w_state_next   = r_state;
    w_cnt_next     = w_cnt_dec;

    case (r_state)
      S_IDLE: begin
        w_state_next = S_THINK;
        w_cnt_next   = THINK_LOAD;
      end
      S_THINK: begin
        if (w_cnt_zero) begin
          if (w_dist > FAR_V) begin
            w_state_next = S_APPROACH;
          end else if (w_dist < NEAR_V) begin
            case (w_r)
              2'd2:    w_state_next = self_jump_active ? S_RETREAT : S_JUMP;
              2'd3:    w_state_next = S_COOLDOWN;
              default: w_state_next = S_RETREAT;
            endcase
          end else if (!w_r[0]) begin
            w_state_next = S_APPROACH;
          end else begin
            w_state_next = self_jump_active ? S_THINK : S_JUMP;
          end
          w_cnt_next = (w_state_next == S_JUMP) ? JUMP_LOAD : THINK_LOAD;
        end
      end
      S_APPROACH: begin
        if ((w_dist <= NEAR_V) || self_x_lock || w_cnt_zero) begin
          w_state_next = S_THINK;
          w_cnt_next   = THINK_LOAD;
        end
      end
      S_RETREAT: begin
        if ((w_dist >= FAR_V) || self_x_lock || w_cnt_zero) begin
          w_state_next = S_THINK;
          w_cnt_next   = THINK_LOAD;
        end
      end
      S_JUMP: begin
        if (w_cnt_zero) begin
          w_state_next = S_COOLDOWN;
          w_cnt_next   = THINK_LOAD;
        end
      end
      S_COOLDOWN: begin
        // Park at zero until the fighter has landed.
        if (w_cnt_zero) begin
          w_cnt_next = '0;
          if (!self_jump_active) begin
            w_state_next = S_THINK;
            w_cnt_next   = THINK_LOAD;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

`ifdef FIGHTER_AI_REACTIVE_EN
    if (((r_state == S_THINK) || (r_state == S_APPROACH)) && opponent_jump_active &&
        (w_dist < NEAR_V)) begin
      w_state_next = S_RETREAT;
      w_cnt_next   = THINK_LOAD;
    end
`endif

    if (!ai_enable) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lfsr       <= SEED_EFF;
      r_move_left  <= 1'b0;
      r_move_right <= 1'b0;
      r_jump       <= 1'b0;
    end else if (SCEN) begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_lfsr       <= w_lfsr_next;
      // Direction is re-evaluated every tick from the live positions.
      r_move_left  <= ((w_state_next == S_APPROACH) && !w_toward_right) ||
                      ((w_state_next == S_RETREAT)  &&  w_toward_right);
      r_move_right <= ((w_state_next == S_APPROACH) &&  w_toward_right) ||
                      ((w_state_next == S_RETREAT)  && !w_toward_right);
      r_jump       <= (w_state_next == S_JUMP);
    end
  end

  assign move_left  = r_move_left;
  assign move_right = r_move_right;
  assign jump       = r_jump;
  assign ai_state   = r_state;

endmodule
